// File: rtl/condlogic_mctx_if.sv
// Condition-logic request/response bundle for one Execute-stage instruction.
//   master: drives the request (valid, context, condition, ALU flags, flag
//           write enables, push/pop, error clear) and observes the results.
//   slave : the condition-logic block; returns the condition result, the gated
//           flag write enables, the current flags, stack occupancy and the
//           sticky error bits.
interface condlogic_mctx_if #(
    parameter int unsigned CW = 1,
    parameter int unsigned SW = 3
);
    logic          ValidE;
    logic [CW-1:0] CtxE;
    logic [3:0]    CondE;
    logic [3:0]    ALUFlags;
    logic [1:0]    FlagWriteE;
    logic          PushE;
    logic          PopE;
    logic          ErrClr;
    logic          CondExE;
    logic [1:0]    FlagWriteQ;
    logic [3:0]    FlagsOut;
    logic [SW-1:0] StackCount;
    logic          OvfErr;
    logic          UdfErr;

    modport master (
        output ValidE, CtxE, CondE, ALUFlags, FlagWriteE, PushE, PopE, ErrClr,
        input  CondExE, FlagWriteQ, FlagsOut, StackCount, OvfErr, UdfErr
    );

    modport slave (
        input  ValidE, CtxE, CondE, ALUFlags, FlagWriteE, PushE, PopE, ErrClr,
        output CondExE, FlagWriteQ, FlagsOut, StackCount, OvfErr, UdfErr
    );
endinterface

// File: rtl/condlogic_mctx.sv
// Multi-context ARM condition logic with a shared NZCV save/restore stack.
// Ports:
//   CLK   - clock, rising edge
//   Reset - asynchronous active-low reset
//   bus   - condlogic_mctx_if slave: request in, condition result / flag
//           state / stack status out
module condlogic_mctx #(
    parameter int unsigned NUM_CTX     = 2,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic CLK,
    input  logic Reset,
    condlogic_mctx_if.slave bus
);
    localparam int unsigned CW       = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam int unsigned SW       = $clog2(STACK_DEPTH + 1);
    // Arrays sized to the full index range so any index width matches exactly;
    // slots beyond NUM_CTX / STACK_DEPTH are never written.
    localparam int unsigned CTX_SLOT = 1 << CW;
    localparam int unsigned STK_SLOT = 1 << SW;

    logic [3:0]    nzcv  [CTX_SLOT];
    logic [3:0]    stack [STK_SLOT];
    logic [SW-1:0] cnt;
    logic          ovf;
    logic          udf;

    logic          ctx_ok, req_valid, cond_pass, cond_ex;
    logic [3:0]    cur, top;
    logic [1:0]    fwq;
    logic [SW-1:0] cnt_m1;
    logic          empty, full;
    logic          both, only_push, only_pop;
    logic          push_w, swap, pop_dec, restore, ovf_ev, udf_ev;

    // Request decode and current-flag read (pre-update, no bypass)
    always_comb begin
        ctx_ok    = 32'(bus.CtxE) < NUM_CTX;
        req_valid = bus.ValidE && ctx_ok;
        cur       = ctx_ok ? nzcv[bus.CtxE] : 4'b0000;
        cnt_m1    = cnt - SW'(1);
        top       = stack[cnt_m1];
    end

    // ARM condition evaluation against {N,Z,C,V}
    always_comb begin
        cond_pass = 1'b0;
        case (bus.CondE)
            4'h0: cond_pass = cur[2];
            4'h1: cond_pass = !cur[2];
            4'h2: cond_pass = cur[1];
            4'h3: cond_pass = !cur[1];
            4'h4: cond_pass = cur[3];
            4'h5: cond_pass = !cur[3];
            4'h6: cond_pass = cur[0];
            4'h7: cond_pass = !cur[0];
            4'h8: cond_pass = cur[1] && !cur[2];
            4'h9: cond_pass = !cur[1] || cur[2];
            4'hA: cond_pass = (cur[3] == cur[0]);
            4'hB: cond_pass = (cur[3] != cur[0]);
            4'hC: cond_pass = !cur[2] && (cur[3] == cur[0]);
            4'hD: cond_pass = cur[2] || (cur[3] != cur[0]);
            default: cond_pass = 1'b1;
        endcase
        cond_ex = req_valid && cond_pass;
        fwq     = bus.FlagWriteE & {2{cond_ex}};
    end

    // Stack operation classification; simultaneous push+pop swaps the top
    always_comb begin
        empty     = (cnt == '0);
        full      = (cnt == SW'(STACK_DEPTH));
        both      = req_valid && bus.PushE && bus.PopE;
        only_push = req_valid && bus.PushE && !bus.PopE;
        only_pop  = req_valid && bus.PopE && !bus.PushE;
        swap      = both && !empty;
        push_w    = (only_push && !full) || (both && empty);
        pop_dec   = only_pop && !empty;
        restore   = swap || pop_dec;
        ovf_ev    = only_push && full;
        udf_ev    = (only_pop && empty) || (both && empty);
    end

    // Flag banks, stack pointer and sticky errors
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < CTX_SLOT; i++) nzcv[i] <= 4'b0000;
            cnt <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (restore) begin
                nzcv[bus.CtxE] <= top;
            end else begin
                if (fwq[1]) nzcv[bus.CtxE][3:2] <= bus.ALUFlags[3:2];
                if (fwq[0]) nzcv[bus.CtxE][1:0] <= bus.ALUFlags[1:0];
            end
            if (push_w)       cnt <= cnt + SW'(1);
            else if (pop_dec) cnt <= cnt_m1;
            ovf <= ovf_ev || (ovf && !bus.ErrClr);
            udf <= udf_ev || (udf && !bus.ErrClr);
        end
    end

    // Stack storage (contents need no reset); writes suppressed during reset
    always_ff @(posedge CLK) begin
        if (Reset && push_w) stack[cnt]    <= cur;
        if (Reset && swap)   stack[cnt_m1] <= cur;
    end

    assign bus.CondExE    = cond_ex;
    assign bus.FlagWriteQ = fwq;
    assign bus.FlagsOut   = cur;
    assign bus.StackCount = cnt;
    assign bus.OvfErr     = ovf;
    assign bus.UdfErr     = udf;
endmodule

// File: tb/tb_condlogic_mctx.sv
// Bench for condlogic_mctx (NUM_CTX=3 so an out-of-range context is reachable,
// STACK_DEPTH=4): directed literal checks, then randomized traffic compared
// every cycle against a queue-based behavioural model.
module tb_condlogic_mctx;
    localparam int unsigned NCTX  = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 2;
    localparam int unsigned SW    = 3;

    logic CLK   = 1'b0;
    logic Reset = 1'b0;
    always #5 CLK = ~CLK;

    condlogic_mctx_if #(.CW(CW), .SW(SW)) bus ();

    condlogic_mctx #(.NUM_CTX(NCTX), .STACK_DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_flags [NCTX];
    logic [3:0] m_stack [$];
    bit         m_ovf, m_udf;

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c)
            0: return z;
            1: return !z;
            2: return cc;
            3: return !cc;
            4: return n;
            5: return !n;
            6: return v;
            7: return !v;
            8: return cc && !z;
            9: return !cc || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] apply_fw(input logic [3:0] f, input logic [1:0] w,
                                            input logic [3:0] alu);
        logic [3:0] r;
        r = f;
        if (w[1]) r[3:2] = alu[3:2];
        if (w[0]) r[1:0] = alu[1:0];
        return r;
    endfunction

    // Compare DUT against the model on every falling edge, then advance model
    always @(negedge CLK) begin
        int         c;
        bit         valid, cex;
        logic [3:0] cur, t;
        logic [1:0] fwq;
        bit         ov_ev, ud_ev;
        if (!Reset) begin
            for (int i = 0; i < NCTX; i++) m_flags[i] = 4'b0000;
            m_stack.delete();
            m_ovf = 0;
            m_udf = 0;
        end
        c     = int'(bus.CtxE);
        valid = bus.ValidE && (c < NCTX);
        cur   = (c < NCTX) ? m_flags[c] : 4'b0000;
        cex   = valid && cond_ok(bus.CondE, cur);
        fwq   = cex ? bus.FlagWriteE : 2'b00;
        chk("CondExE",    int'(bus.CondExE),    int'(cex));
        chk("FlagWriteQ", int'(bus.FlagWriteQ), int'(fwq));
        chk("FlagsOut",   int'(bus.FlagsOut),   int'(cur));
        chk("StackCount", int'(bus.StackCount), m_stack.size());
        chk("OvfErr",     int'(bus.OvfErr),     int'(m_ovf));
        chk("UdfErr",     int'(bus.UdfErr),     int'(m_udf));
        if (Reset) begin
            ov_ev = 0;
            ud_ev = 0;
            if (valid) begin
                if (bus.PushE && bus.PopE) begin
                    if (m_stack.size() > 0) begin
                        t = m_stack[m_stack.size()-1];
                        m_stack[m_stack.size()-1] = cur;
                        m_flags[c] = t;
                    end else begin
                        m_stack.push_back(cur);
                        ud_ev = 1;
                        m_flags[c] = apply_fw(cur, fwq, bus.ALUFlags);
                    end
                end else if (bus.PushE) begin
                    if (m_stack.size() < DEPTH) m_stack.push_back(cur);
                    else ov_ev = 1;
                    m_flags[c] = apply_fw(cur, fwq, bus.ALUFlags);
                end else if (bus.PopE) begin
                    if (m_stack.size() > 0) m_flags[c] = m_stack.pop_back();
                    else begin
                        ud_ev = 1;
                        m_flags[c] = apply_fw(cur, fwq, bus.ALUFlags);
                    end
                end else begin
                    m_flags[c] = apply_fw(cur, fwq, bus.ALUFlags);
                end
            end
            if (bus.ErrClr) begin
                m_ovf = 0;
                m_udf = 0;
            end
            if (ov_ev) m_ovf = 1;
            if (ud_ev) m_udf = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input bit v, input int ctx, input int cond, input int alu,
                          input int fwe, input bit push, input bit pop, input bit clr);
        bus.ValidE     = v;
        bus.CtxE       = CW'(ctx);
        bus.CondE      = 4'(cond);
        bus.ALUFlags   = 4'(alu);
        bus.FlagWriteE = 2'(fwe);
        bus.PushE      = push;
        bus.PopE       = pop;
        bus.ErrClr     = clr;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle0();
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
    endtask

    int exp_pop [5] = '{3, 2, 1, 4, 4};

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b1;

        // Reset state
        idle0();
        chk("rst CondExE", int'(bus.CondExE), 0);
        chk("rst FlagsOut", int'(bus.FlagsOut), 0);
        chk("rst StackCount", int'(bus.StackCount), 0);
        chk("rst OvfErr", int'(bus.OvfErr), 0);
        chk("rst UdfErr", int'(bus.UdfErr), 0);
        step();

        // ctx0 write Z
        set_in(1, 0, 14, 4'b0100, 3, 0, 0, 0); #1;
        chk("wr FlagWriteQ", int'(bus.FlagWriteQ), 3);
        step();
        idle0();
        chk("ctx0 FlagsOut", int'(bus.FlagsOut), 4);
        chk("EQ passes", int'(bus.CondExE), 1);
        bus.CondE = 4'h1; #1;
        chk("NE fails", int'(bus.CondExE), 0);
        step();

        // Failed condition on ctx1 suppresses write
        set_in(1, 1, 0, 4'b1111, 3, 0, 0, 0); #1;
        chk("ctx1 CondExE", int'(bus.CondExE), 0);
        chk("ctx1 FlagWriteQ", int'(bus.FlagWriteQ), 0);
        step();
        set_in(1, 1, 0, 0, 0, 0, 0, 0); #1;
        chk("ctx1 unchanged", int'(bus.FlagsOut), 0);
        bus.CtxE = 2'd0; #1;
        chk("ctx0 unaffected", int'(bus.FlagsOut), 4);

        // Five pushes with writes, overflow on the fifth
        for (int k = 1; k <= 5; k++) begin
            set_in(1, 0, 14, k, 3, 1, 0, 0);
            step();
        end
        idle0();
        chk("full count", int'(bus.StackCount), 4);
        chk("ovf set", int'(bus.OvfErr), 1);
        chk("write after ovf", int'(bus.FlagsOut), 5);
        set_in(1, 0, 0, 0, 0, 0, 0, 1);
        step();
        idle0();
        chk("ovf cleared", int'(bus.OvfErr), 0);

        // Five pops restore LIFO, underflow on the fifth
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 1, 0);
            step();
            idle0();
            chk($sformatf("pop%0d FlagsOut", i), int'(bus.FlagsOut), exp_pop[i]);
        end
        chk("empty count", int'(bus.StackCount), 0);
        chk("udf set", int'(bus.UdfErr), 1);
        set_in(1, 0, 0, 0, 0, 0, 0, 1);
        step();

        // Swap: ctx0=1010, top=0101
        set_in(1, 0, 14, 4'b0101, 3, 0, 0, 0); step();
        set_in(1, 0, 0, 0, 0, 1, 0, 0); step();
        set_in(1, 0, 14, 4'b1010, 3, 0, 0, 0); step();
        idle0();
        chk("pre-swap flags", int'(bus.FlagsOut), 10);
        chk("pre-swap count", int'(bus.StackCount), 1);
        set_in(1, 0, 0, 0, 0, 1, 1, 0); step();
        idle0();
        chk("swap flags", int'(bus.FlagsOut), 5);
        chk("swap count", int'(bus.StackCount), 1);
        chk("swap no ovf", int'(bus.OvfErr), 0);
        set_in(1, 0, 0, 0, 0, 0, 1, 0); step();
        idle0();
        chk("old ctx in top", int'(bus.FlagsOut), 10);
        chk("after pop count", int'(bus.StackCount), 0);

        // Invalid requests: ValidE=0 and out-of-range context
        set_in(0, 0, 14, 4'b1111, 3, 1, 0, 0); #1;
        chk("inv CondExE", int'(bus.CondExE), 0);
        chk("inv FlagWriteQ", int'(bus.FlagWriteQ), 0);
        step();
        set_in(1, 3, 14, 4'b1111, 3, 1, 0, 0); #1;
        chk("badctx CondExE", int'(bus.CondExE), 0);
        chk("badctx FlagWriteQ", int'(bus.FlagWriteQ), 0);
        step();
        idle0();
        chk("inv ctx0 kept", int'(bus.FlagsOut), 10);
        chk("inv count kept", int'(bus.StackCount), 0);
        bus.CtxE = 2'd2; #1;
        chk("inv ctx2 kept", int'(bus.FlagsOut), 0);

        // Reset mid-operation
        set_in(1, 0, 14, 4'b0110, 3, 1, 0, 0); step();
        set_in(1, 0, 14, 4'b0111, 3, 1, 0, 0);
        Reset = 1'b0; #1;
        chk("midrst FlagsOut", int'(bus.FlagsOut), 0);
        chk("midrst count", int'(bus.StackCount), 0);
        step();
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        step();
        idle0();
        chk("postrst FlagsOut", int'(bus.FlagsOut), 0);
        chk("postrst count", int'(bus.StackCount), 0);
        chk("postrst ovf", int'(bus.OvfErr), 0);
        chk("postrst udf", int'(bus.UdfErr), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 3),
                   $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                   $urandom_range(0, 9) == 0);
            if (!Reset) Reset = 1'b1;
            else if ($urandom_range(0, 99) == 0) Reset = 1'b0;
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
